// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : seg_pkg
//  Description : Shared constants, scan-state encoding and the hex to
//                active-low seven-segment table used by the scan driver.
//  Contents    : SEG_OFF / EN_OFF blanking constants, scan_state_t,
//                hex_to_seg() lookup function.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // All segments dark / all digits disabled (active-low bus).
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] EN_OFF  = 4'hF;

    // Per-slot scan phase: blanking guard, then the driven window.
    typedef enum logic [0:0] {
        GUARD_ST = 1'b0,
        DRIVE_ST = 1'b1
    } scan_state_t;

    // Segment order {a,b,c,d,e,f,g}, active-low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational hex nibble to active-low 7-segment decoder.
//  Ports       : hex  in  4  nibble to display
//                seg  out 7  {a,b,c,d,e,f,g}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed 4-digit seven-segment scanner with
//                anti-ghost guard time, leading-zero blanking, per-digit
//                blinking and per-frame input capture.
//  Ports       : FPGA_CLK   in  1   system clock
//                RST_N      in  1   asynchronous active-low reset
//                digits     in  16  {d3,d2,d1,d0}, d0 rightmost
//                dot_mask   in  4   bit i lights dot of digit i
//                blink_mask in  4   bit i makes digit i blink
//                blank_lz   in  1   blank leading zeros d3..d1
//                segment    out 7   {a..g}, active-low
//                en_seg     out 4   digit enables, active-low
//                dot        out 1   decimal point, active-low
//                frame_tick out 1   pulse after each shadow capture
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 500,
    parameter int BLINK_DIV = 12500000
) (
    input  logic        FPGA_CLK,
    input  logic        RST_N,
    input  logic [15:0] digits,
    input  logic [3:0]  dot_mask,
    input  logic [3:0]  blink_mask,
    input  logic        blank_lz,
    output logic [6:0]  segment,
    output logic [3:0]  en_seg,
    output logic        dot,
    output logic        frame_tick
);

    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SLOT_W-1:0]  slot_cnt;
    logic [1:0]         idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    logic [15:0] sh_digits;
    logic [3:0]  sh_dot_mask;
    logic [3:0]  sh_blink_mask;
    logic        sh_blank_lz;

    scan_state_t state;
    logic        slot_wrap;
    logic        blink_wrap;
    logic        capture;
    logic [3:0]  cur_digit;
    logic [6:0]  cur_seg;
    logic        lead_zero;
    logic        suppress;

    assign slot_wrap  = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
    assign capture    = (idx == 2'd0) && (slot_cnt == '0);

    // State is a pure function of the slot position; the output registers
    // below supply the single cycle of latency.
    assign state = (slot_cnt < SLOT_W'(GUARD)) ? GUARD_ST : DRIVE_ST;

    always_comb begin
        cur_digit = sh_digits[3:0];
        lead_zero = 1'b0;
        case (idx)
            2'd0: begin
                cur_digit = sh_digits[3:0];
                lead_zero = 1'b0;
            end
            2'd1: begin
                cur_digit = sh_digits[7:4];
                lead_zero = (sh_digits[15:4] == 12'h000);
            end
            2'd2: begin
                cur_digit = sh_digits[11:8];
                lead_zero = (sh_digits[15:8] == 8'h00);
            end
            default: begin
                cur_digit = sh_digits[15:12];
                lead_zero = (sh_digits[15:12] == 4'h0);
            end
        endcase
    end

    // The blink term uses the live phase, so a toggle lands mid-slot.
    assign suppress = (sh_blank_lz && lead_zero) || (blink_phase && sh_blink_mask[idx]);

    hex_to_seg7 u_dec (
        .hex (cur_digit),
        .seg (cur_seg)
    );

    // Slot / digit scan counters.
    always_ff @(posedge FPGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_cnt <= '0;
            idx      <= 2'd0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Free-running blink timebase, independent of slot timing.
    always_ff @(posedge FPGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
    end

    // Frame-boundary shadow capture. The capture cycle is always inside
    // GUARD_ST, so the new shadow is in place before anything is driven.
    always_ff @(posedge FPGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_digits     <= 16'h0000;
            sh_dot_mask   <= 4'h0;
            sh_blink_mask <= 4'h0;
            sh_blank_lz   <= 1'b0;
            frame_tick    <= 1'b0;
        end else begin
            frame_tick <= capture;
            if (capture) begin
                sh_digits     <= digits;
                sh_dot_mask   <= dot_mask;
                sh_blink_mask <= blink_mask;
                sh_blank_lz   <= blank_lz;
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge FPGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            en_seg  <= EN_OFF;
            segment <= SEG_OFF;
            dot     <= 1'b1;
        end else if ((state == DRIVE_ST) && !suppress) begin
            en_seg  <= ~(4'b0001 << idx);
            segment <= cur_seg;
            dot     <= ~sh_dot_mask[idx];
        end else begin
            en_seg  <= EN_OFF;
            segment <= SEG_OFF;
            dot     <= 1'b1;
        end
    end

endmodule
`default_nettype wire
